// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the conv MAC array.
// Lane widths come from module parameters; this package holds only width-independent pieces.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bias add, round half up, arithmetic shift and saturation to a signed width-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input logic signed [63:0] bias,
                                                   input int frac_bits,
                                                   input int width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s = acc + bias;
    if (frac_bits > 0) s = (s + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/conv_mac_array_if.sv
// Tap stream, weight/bias ROM and output bus of the conv MAC array.
interface conv_mac_array_if #(
  parameter int WIDTH  = 16,
  parameter int DSP_NO = 256,
  parameter int ADDR_W = 7
);
  logic                      start_i;
  logic                      en_i;
  logic signed [WIDTH-1:0]   ifm_i;
  logic [ADDR_W-1:0]         weight_addr_o;
  logic signed [WIDTH-1:0]   weight_i [DSP_NO];
  logic signed [2*WIDTH-1:0] bias_i [DSP_NO];
  logic signed [WIDTH-1:0]   ofm_o [DSP_NO];
  logic                      ofm_valid_o;
  logic                      busy_o;
  logic                      done_o;
  logic                      err_o;

  modport master (
    output start_i, en_i, ifm_i, weight_i, bias_i,
    input  weight_addr_o, ofm_o, ofm_valid_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, en_i, ifm_i, weight_i, bias_i,
    output weight_addr_o, ofm_o, ofm_valid_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/conv_mac_array_mac_lane.sv
// One output channel: registered operands, first-tap load / accumulate, then
// bias, rounding, saturation and optional ReLU into the output register.
module mac_lane
  import conv_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_W     = 39,
  parameter int FRAC_BITS = 14,
  parameter int RELU_EN   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tap_en,
  input  logic                      acc_en,
  input  logic                      first,
  input  logic                      out_en,
  input  logic signed [WIDTH-1:0]   ifm,
  input  logic signed [WIDTH-1:0]   weight,
  input  logic signed [2*WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0]   ofm
);
  logic signed [WIDTH-1:0]   ifm_q;
  logic signed [WIDTH-1:0]   weight_q;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc;
  logic signed [63:0]        res;

  assign prod = ifm_q * weight_q;
  assign res  = sat_round(64'(acc), 64'(bias), FRAC_BITS, WIDTH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifm_q    <= '0;
      weight_q <= '0;
      acc      <= '0;
      ofm      <= '0;
    end else begin
      if (tap_en) begin
        ifm_q    <= ifm;
        weight_q <= weight;
      end
      // Loading on the first tap lets the next pixel start without a clear cycle.
      if (acc_en) acc <= first ? ACC_W'(prod) : acc + ACC_W'(prod);
      if (out_en) ofm <= ((RELU_EN != 0) && res[63]) ? '0 : res[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/conv_mac_array.sv
// Parametrised conv layer engine: layer FSM, tap/pixel counters and the flag
// pipeline that steers DSP_NO mac_lane instances.
//
//   state | meaning
//   IDLE  | after reset, waiting for start_i
//   RUN   | accepting taps, pixels in flight
//   DONE  | last pixel written, waiting for start_i
module conv_mac_array
  import conv_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DSP_NO     = 256,
  parameter int CHIN       = 112,
  parameter int KERNEL_DIM = 1,
  parameter int WOUT       = 8,
  parameter int FRAC_BITS  = 14,
  parameter int RELU_EN    = 1
) (
  input logic            clk,
  input logic            rst,
  conv_mac_array_if.slave bus
);
  localparam int TAPS   = KERNEL_DIM * KERNEL_DIM * CHIN;
  localparam int ADDR_W = addr_w(TAPS);
  localparam int ACC_W  = 2 * WIDTH + $clog2(TAPS);
  localparam int NPIX   = WOUT * WOUT;
  localparam int PIX_W  = addr_w(NPIX);

  state_t              state, state_nx;
  logic                start_ok;
  logic                tap_en;
  logic [ADDR_W-1:0]   tap_cnt;
  logic [PIX_W-1:0]    pix_cnt;
  logic                v1, first1, last1, last2;
  logic                ofm_valid;
  logic                err;
  logic signed [WIDTH-1:0] ofm [DSP_NO];

  assign tap_en = bus.en_i && (state == RUN);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    unique case (state)
      IDLE: if (bus.start_i) begin
        state_nx = RUN;
        start_ok = 1'b1;
      end
      RUN:  if (ofm_valid && (pix_cnt == PIX_W'(NPIX - 1))) state_nx = DONE;
      DONE: if (bus.start_i) begin
        state_nx = RUN;
        start_ok = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tap_cnt   <= '0;
      pix_cnt   <= '0;
      err       <= 1'b0;
      v1        <= 1'b0;
      first1    <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
      ofm_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        tap_cnt <= '0;
        pix_cnt <= '0;
      end else begin
        if (tap_en)
          tap_cnt <= (tap_cnt == ADDR_W'(TAPS - 1)) ? '0 : tap_cnt + ADDR_W'(1);
        if (ofm_valid)
          pix_cnt <= (pix_cnt == PIX_W'(NPIX - 1)) ? '0 : pix_cnt + PIX_W'(1);
      end
      if (start_ok)                         err <= 1'b0;
      else if (bus.en_i && (state != RUN))  err <= 1'b1;
      v1        <= tap_en;
      first1    <= tap_en && (tap_cnt == '0);
      last1     <= tap_en && (tap_cnt == ADDR_W'(TAPS - 1));
      last2     <= last1;
      ofm_valid <= last2;
    end
  end

  for (genvar g = 0; g < DSP_NO; g++) begin : g_lane
    mac_lane #(
      .WIDTH    (WIDTH),
      .ACC_W    (ACC_W),
      .FRAC_BITS(FRAC_BITS),
      .RELU_EN  (RELU_EN)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .tap_en(tap_en),
      .acc_en(v1),
      .first (first1),
      .out_en(last2),
      .ifm   (bus.ifm_i),
      .weight(bus.weight_i[g]),
      .bias  (bus.bias_i[g]),
      .ofm   (ofm[g])
    );
  end

  assign bus.weight_addr_o = tap_cnt;
  assign bus.ofm_o         = ofm;
  assign bus.ofm_valid_o   = ofm_valid;
  assign bus.busy_o        = (state == RUN);
  assign bus.done_o        = (state == DONE);
  assign bus.err_o         = err;
endmodule

// File: tb/tb_conv_mac_array.sv
// Bench for conv_mac_array: two instances (ReLU on / off) share one stimulus stream;
// results are compared against a table of hand-derived values and an arithmetic model.
module tb_conv_mac_array;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_mac_array_if #(.WIDTH(16), .DSP_NO(2), .ADDR_W(2)) b1 ();
  conv_mac_array_if #(.WIDTH(16), .DSP_NO(2), .ADDR_W(2)) b0 ();

  assign b0.start_i  = b1.start_i;
  assign b0.en_i     = b1.en_i;
  assign b0.ifm_i    = b1.ifm_i;
  assign b0.weight_i = b1.weight_i;
  assign b0.bias_i   = b1.bias_i;

  conv_mac_array #(.WIDTH(16), .DSP_NO(2), .CHIN(4), .KERNEL_DIM(1), .WOUT(2),
                   .FRAC_BITS(14), .RELU_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  conv_mac_array #(.WIDTH(16), .DSP_NO(2), .CHIN(4), .KERNEL_DIM(1), .WOUT(2),
                   .FRAC_BITS(14), .RELU_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  typedef struct {
    int cyc;
    int r1_0, r1_1, r0_0, r0_1;
  } exp_t;

  typedef struct {
    int px, w0, w1;
    longint b0, b1;
    int e1_0, e1_1, e0_0, e0_1;
  } vec_t;

  int      checks = 0;
  int      failures = 0;
  int      cyc_m = 0;
  exp_t    exp_q[$];
  exp_t    me;
  vec_t    tbl[8];
  int      cur_px[4];
  int      cur_w[4][2];
  longint  cur_b[2];
  int      lay_px[4][4];
  int      lay_w[4][4][2];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_m);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_lane(input int lane, input bit relu);
    longint s = cur_b[lane];
    for (int t = 0; t < 4; t++) s += longint'(cur_px[t]) * longint'(cur_w[t][lane]);
    s = (s + 8192) >>> 14;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return int'(s);
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.cyc  = 0;
    e.r1_0 = model_lane(0, 1'b1);
    e.r1_1 = model_lane(1, 1'b1);
    e.r0_0 = model_lane(0, 1'b0);
    e.r0_1 = model_lane(1, 1'b0);
    return e;
  endfunction

  // Every output pulse is matched in order against the expected queue.
  always @(posedge clk) begin
    cyc_m++;
    #2;
    if (b1.ofm_valid_o !== b0.ofm_valid_o)
      chk("valid_relu_vs_norelu", longint'(b0.ofm_valid_o), longint'(b1.ofm_valid_o));
    if (b1.ofm_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", longint'(b1.ofm_valid_o), 0);
      end else begin
        me = exp_q.pop_front();
        chk("valid_cycle", cyc_m, me.cyc);
        chk("ofm_relu_l0", longint'(b1.ofm_o[0]), me.r1_0);
        chk("ofm_relu_l1", longint'(b1.ofm_o[1]), me.r1_1);
        chk("ofm_norelu_l0", longint'(b0.ofm_o[0]), me.r0_0);
        chk("ofm_norelu_l1", longint'(b0.ofm_o[1]), me.r0_1);
      end
    end
  end

  task automatic drive_tap(input int t);
    b1.en_i        = 1'b1;
    b1.ifm_i       = 16'(cur_px[t]);
    b1.weight_i[0] = 16'(cur_w[t][0]);
    b1.weight_i[1] = 16'(cur_w[t][1]);
  endtask

  task automatic feed_pixel(input int gap_max, input exp_t e);
    b1.bias_i[0] = 32'(cur_b[0]);
    b1.bias_i[1] = 32'(cur_b[1]);
    for (int t = 0; t < 4; t++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        b1.en_i        = 1'b0;
        b1.ifm_i       = 16'($urandom);
        b1.weight_i[0] = 16'($urandom);
        b1.weight_i[1] = 16'($urandom);
        step();
      end
      chk("weight_addr", longint'(b1.weight_addr_o), t);
      chk("weight_addr_norelu", longint'(b0.weight_addr_o), t);
      drive_tap(t);
      if (t == 3) e.cyc = cyc_m + 3;
      step();
    end
    b1.en_i = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic start_layer();
    b1.start_i = 1'b1;
    step();
    b1.start_i = 1'b0;
    chk("start_busy", longint'(b1.busy_o), 1);
    chk("start_done", longint'(b1.done_o), 0);
    chk("start_err", longint'(b1.err_o), 0);
    chk("start_err_norelu", longint'(b0.err_o), 0);
  endtask

  task automatic wait_drain(input bit check_done);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    if (check_done) begin
      chk("done", longint'(b1.done_o), 1);
      chk("done_busy", longint'(b1.busy_o), 0);
      chk("done_norelu", longint'(b0.done_o), 1);
    end
  endtask

  task automatic load_tbl(input int i, output exp_t e);
    for (int t = 0; t < 4; t++) begin
      cur_px[t]   = tbl[i].px;
      cur_w[t][0] = tbl[i].w0;
      cur_w[t][1] = tbl[i].w1;
    end
    cur_b[0] = tbl[i].b0;
    cur_b[1] = tbl[i].b1;
    e.cyc  = 0;
    e.r1_0 = tbl[i].e1_0;
    e.r1_1 = tbl[i].e1_1;
    e.r0_0 = tbl[i].e0_0;
    e.r0_1 = tbl[i].e0_1;
  endtask

  task automatic load_pix(input int p);
    for (int t = 0; t < 4; t++) begin
      cur_px[t]   = lay_px[p][t];
      cur_w[t][0] = lay_w[p][t][0];
      cur_w[t][1] = lay_w[p][t][1];
    end
  endtask

  task automatic gen_layer(input bit wide);
    for (int p = 0; p < 4; p++)
      for (int t = 0; t < 4; t++) begin
        lay_px[p][t] = wide ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(4000)) - 2000;
        for (int l = 0; l < 2; l++)
          lay_w[p][t][l] = wide ? int'($urandom_range(65535)) - 32768 : int'($urandom_range(16000)) - 8000;
      end
    cur_b[0] = longint'($urandom_range(2000000)) - 1000000;
    cur_b[1] = longint'($urandom_range(2000000)) - 1000000;
  endtask

  task automatic run_rand_layer(input int gap_max);
    start_layer();
    for (int p = 0; p < 4; p++) begin
      load_pix(p);
      feed_pixel(gap_max, model_exp());
    end
    wait_drain(1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int sv1[2];
    int sv0[2];

    //        px      w0      w1      b0     b1    relu l0 l1     norelu l0 l1
    tbl[0] = '{4096,  16384,  16384,  0,     0,     16384, 16384,  16384,  16384};
    tbl[1] = '{4096,  16384, -16384,  16384, 0,     16385, 0,      16385, -16384};
    tbl[2] = '{32767, 32767,  32767,  0,     0,     32767, 32767,  32767,  32767};
    tbl[3] = '{-32768,32767,  32767,  0,     0,     0,     0,     -32768, -32768};
    tbl[4] = '{2048,  1,     -1,      0,     0,     1,     0,      1,      0};
    tbl[5] = '{0,     0,      0,     -8193,  8191,  0,     0,     -1,      0};
    tbl[6] = '{0,     0,      0,      8192,  8191,  1,     0,      1,      0};
    tbl[7] = '{1,    -1,      1,     -8188, -8197,  0,     0,      0,     -1};

    rst = 1'b0;
    b1.start_i = 1'b0;
    b1.en_i = 1'b0;
    b1.ifm_i = '0;
    b1.weight_i[0] = '0;
    b1.weight_i[1] = '0;
    b1.bias_i[0] = '0;
    b1.bias_i[1] = '0;
    repeat (3) step();
    chk("rst_weight_addr", longint'(b1.weight_addr_o), 0);
    chk("rst_ofm_l0", longint'(b1.ofm_o[0]), 0);
    chk("rst_ofm_l1", longint'(b1.ofm_o[1]), 0);
    chk("rst_valid", longint'(b1.ofm_valid_o), 0);
    chk("rst_busy", longint'(b1.busy_o), 0);
    chk("rst_done", longint'(b1.done_o), 0);
    chk("rst_err", longint'(b1.err_o), 0);
    rst = 1'b1;
    step();

    // Tap while idle: flagged, otherwise ignored.
    b1.en_i = 1'b1;
    b1.ifm_i = 16'(1234);
    step();
    b1.en_i = 1'b0;
    chk("idle_err", longint'(b1.err_o), 1);
    chk("idle_weight_addr", longint'(b1.weight_addr_o), 0);
    chk("idle_busy", longint'(b1.busy_o), 0);

    start_layer();
    for (int i = 0; i < 4; i++) begin
      load_tbl(i, e);
      feed_pixel(0, e);
      repeat (3) step();
    end
    wait_drain(1'b1);

    // Taps in DONE must not disturb anything but err.
    sv1[0] = int'(b1.ofm_o[0]); sv1[1] = int'(b1.ofm_o[1]);
    sv0[0] = int'(b0.ofm_o[0]); sv0[1] = int'(b0.ofm_o[1]);
    for (int k = 0; k < 2; k++) begin
      b1.en_i = 1'b1;
      b1.ifm_i = 16'($urandom);
      b1.weight_i[0] = 16'($urandom);
      b1.weight_i[1] = 16'($urandom);
      step();
    end
    b1.en_i = 1'b0;
    repeat (5) step();
    chk("done_err", longint'(b1.err_o), 1);
    chk("done_err_norelu", longint'(b0.err_o), 1);
    chk("done_hold_l0", longint'(b1.ofm_o[0]), sv1[0]);
    chk("done_hold_l1", longint'(b1.ofm_o[1]), sv1[1]);
    chk("done_hold_norelu_l0", longint'(b0.ofm_o[0]), sv0[0]);
    chk("done_hold_norelu_l1", longint'(b0.ofm_o[1]), sv0[1]);
    chk("done_weight_addr", longint'(b1.weight_addr_o), 0);
    chk("done_still", longint'(b1.done_o), 1);

    start_layer();
    for (int i = 4; i < 8; i++) begin
      load_tbl(i, e);
      feed_pixel(0, e);
      repeat (3) step();
    end
    wait_drain(1'b1);

    // Same random layer gapless and with stalls; both must match the model.
    for (int rep = 0; rep < 3; rep++) begin
      gen_layer(rep == 2);
      run_rand_layer(0);
      run_rand_layer(3);
    end

    // Reset in the middle of the second pixel, asserted together with start and en.
    start_layer();
    load_tbl(0, e);
    feed_pixel(0, e);
    wait_drain(1'b0);
    load_tbl(1, e);
    b1.bias_i[0] = 32'(cur_b[0]);
    b1.bias_i[1] = 32'(cur_b[1]);
    for (int t = 0; t < 2; t++) begin
      chk("abort_weight_addr", longint'(b1.weight_addr_o), t);
      drive_tap(t);
      step();
    end
    rst = 1'b0;
    b1.start_i = 1'b1;
    b1.en_i = 1'b1;
    step();
    rst = 1'b1;
    b1.start_i = 1'b0;
    b1.en_i = 1'b0;
    chk("abort_weight_addr_rst", longint'(b1.weight_addr_o), 0);
    chk("abort_ofm_l0", longint'(b1.ofm_o[0]), 0);
    chk("abort_ofm_l1", longint'(b1.ofm_o[1]), 0);
    chk("abort_ofm_norelu_l1", longint'(b0.ofm_o[1]), 0);
    chk("abort_valid", longint'(b1.ofm_valid_o), 0);
    chk("abort_busy", longint'(b1.busy_o), 0);
    chk("abort_done", longint'(b1.done_o), 0);
    chk("abort_err", longint'(b1.err_o), 0);
    repeat (4) step();

    gen_layer(1'b0);
    run_rand_layer(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
